// File: rtl/pkt_134b_to_gmii.sv
// Egress serializer: buffers complete 134b packet beats in a store-and-forward FIFO
// and replays each frame as a contiguous GMII byte stream (optional preamble, fixed IFG).
module pkt_134b_to_gmii #(
    parameter int FIFO_AW     = 8,
    parameter bit PREAMBLE_EN = 1'b1,
    parameter int IFG_CYCLES  = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [133:0] pkt_data,
    input  logic         pkt_data_valid,
    output logic         ready_out,
    output logic [7:0]   gmii_data,
    output logic         gmii_data_valid,
    output logic [31:0]  cnt_pkt,
    output logic [31:0]  cnt_drop
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;
    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_IFG} state_t;

    // Handshake: a beat is offered whenever pkt_data_valid is high; it is stored if the
    // FIFO has room, otherwise dropped. ready_out (free >= 2, registered) is advisory and
    // leaves room for exactly one beat sent in the cycle after it falls.

    // Beat storage: payload plus a separate control field {tail_flag, valid}
    logic [127:0]        r_mem [DEPTH];
    logic [4:0]          r_ctl [DEPTH];
    logic [127:0]        r_beat_data;
    logic [4:0]          r_beat_ctl;

    logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [PW-1:0]       r_pkt_cnt;
    logic                r_in_pkt;
    logic                r_ready;
    logic [31:0]         r_cnt_drop, r_cnt_pkt;

    state_t              r_state;
    logic [2:0]          r_pre_idx;
    logic [3:0]          r_byte_idx;
    logic [IFG_W-1:0]    r_ifg_cnt;
    logic [7:0]          r_gmii_data;
    logic                r_gmii_valid;

    logic                w_full, w_orphan, w_close, w_wr_en, w_drop;
    logic [FIFO_AW-1:0]  w_wr_idx, w_prev_idx, w_rd_idx;
    logic [PW-1:0]       w_wr_ptr_nxt, w_rd_ptr_nxt, w_used_nxt;
    logic [1:0]          w_pkt_inc;
    logic                w_beat_tail, w_pop, w_pop_tail, w_rd_en;
    logic [3:0]          w_last_idx;
    logic [6:0]          w_byte_lsb;
    logic [7:0]          w_cur_byte;

    // Write side decode; bit 132 marks a head (01/11), bit 133 a tail (10/11)
    assign w_full       = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                          (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_orphan     = pkt_data_valid && !r_in_pkt && !pkt_data[132];
    assign w_close      = pkt_data_valid && r_in_pkt && pkt_data[132];
    assign w_wr_en      = pkt_data_valid && !w_orphan && !w_full;
    assign w_drop       = pkt_data_valid && !w_wr_en;
    assign w_wr_idx     = r_wr_ptr[FIFO_AW-1:0];
    assign w_prev_idx   = w_wr_idx - FIFO_AW'(1);
    assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_en);
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
    assign w_used_nxt   = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_pkt_inc    = {1'b0, w_close} + {1'b0, w_wr_en && pkt_data[133]};

    // Read side: the beat register holds the beat currently being serialized
    assign w_beat_tail  = r_beat_ctl[4];
    assign w_last_idx   = w_beat_tail ? r_beat_ctl[3:0] : 4'hf;
    assign w_pop        = (r_state == S_DATA) && (r_byte_idx == w_last_idx);
    assign w_pop_tail   = w_pop && w_beat_tail;
    assign w_rd_en      = ((r_state == S_IDLE) && (r_pkt_cnt != '0)) || (w_pop && !w_beat_tail);
    assign w_rd_idx     = w_rd_ptr_nxt[FIFO_AW-1:0];
    assign w_byte_lsb   = 7'd120 - {r_byte_idx, 3'b000};
    assign w_cur_byte   = r_beat_data[w_byte_lsb +: 8];

    // Closing an open packet rewrites only the control of its last stored beat
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= pkt_data[127:0];
            r_ctl[w_wr_idx] <= {pkt_data[133], pkt_data[131:128]};
        end
        if (w_close) begin
            r_ctl[w_prev_idx] <= 5'b1_1111;
        end
        if (w_rd_en) begin
            r_beat_data <= r_mem[w_rd_idx];
            r_beat_ctl  <= r_ctl[w_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_pkt_cnt  <= '0;
            r_in_pkt   <= 1'b0;
            r_ready    <= 1'b0;
            r_cnt_drop <= '0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_ready   <= (w_used_nxt <= PW'(DEPTH - 2));
            r_pkt_cnt <= r_pkt_cnt + PW'(w_pkt_inc) - PW'(w_pop_tail);
            if (w_drop) begin
                r_cnt_drop <= r_cnt_drop + 32'd1;
            end
            if (w_wr_en) begin
                r_in_pkt <= !pkt_data[133];
            end else if (w_close) begin
                r_in_pkt <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rd_ptr     <= '0;
            r_pre_idx    <= '0;
            r_byte_idx   <= '0;
            r_ifg_cnt    <= '0;
            r_gmii_data  <= '0;
            r_gmii_valid <= 1'b0;
            r_cnt_pkt    <= '0;
        end else begin
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_gmii_data  <= '0;
            r_gmii_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pkt_cnt != '0) begin
                        r_state    <= PREAMBLE_EN ? S_PRE : S_DATA;
                        r_pre_idx  <= '0;
                        r_byte_idx <= '0;
                    end
                end
                S_PRE: begin
                    r_gmii_valid <= 1'b1;
                    r_gmii_data  <= (r_pre_idx == 3'd7) ? 8'hD5 : 8'h55;
                    r_pre_idx    <= r_pre_idx + 3'd1;
                    if (r_pre_idx == 3'd7) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_gmii_valid <= 1'b1;
                    r_gmii_data  <= w_cur_byte;
                    if (w_pop) begin
                        r_byte_idx <= '0;
                        if (w_beat_tail) begin
                            r_cnt_pkt <= r_cnt_pkt + 32'd1;
                            r_ifg_cnt <= '0;
                            r_state   <= S_IFG;
                        end
                    end else begin
                        r_byte_idx <= r_byte_idx + 4'd1;
                    end
                end
                S_IFG: begin
                    if (r_ifg_cnt == IFG_W'(IFG_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + IFG_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_out       = r_ready;
    assign gmii_data       = r_gmii_data;
    assign gmii_data_valid = r_gmii_valid;
    assign cnt_pkt         = r_cnt_pkt;
    assign cnt_drop        = r_cnt_drop;
endmodule

// File: tb/tb_pkt_134b_to_gmii.sv
// Directed bench for pkt_134b_to_gmii: framing, preamble/IFG timing, FIFO full,
// orphan/partial packet handling and asynchronous reset.
module tb_pkt_134b_to_gmii;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [133:0] pkt_data;
  logic         pkt_data_valid;
  logic         ready_out;
  logic [7:0]   gmii_data;
  logic         gmii_data_valid;
  logic [31:0]  cnt_pkt;
  logic [31:0]  cnt_drop;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [8:0] mon_q[$];
  int         gap_q[$];
  int         tail_idle;
  int         base;

  pkt_134b_to_gmii #(.FIFO_AW(8), .PREAMBLE_EN(1'b1), .IFG_CYCLES(12)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pkt_data        (pkt_data),
    .pkt_data_valid  (pkt_data_valid),
    .ready_out       (ready_out),
    .gmii_data       (gmii_data),
    .gmii_data_valid (gmii_data_valid),
    .cnt_pkt         (cnt_pkt),
    .cnt_drop        (cnt_drop)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) mon_q.push_back({gmii_data_valid, gmii_data});

  // checker
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  function automatic logic [127:0] make_data(input logic [7:0] seed);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[127-8*k -: 8] = seed + 8'(k);
    return d;
  endfunction

  task automatic send_beat(input logic [1:0] t, input logic [3:0] v, input logic [7:0] seed);
    pkt_data       = {t, v, make_data(seed)};
    pkt_data_valid = 1'b1;
    @(negedge clk);
    pkt_data_valid = 1'b0;
  endtask

  task automatic exp_frame_start();
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
  endtask

  task automatic exp_bytes(input logic [7:0] seed, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(seed + 8'(k));
  endtask

  task automatic do_reset();
    pkt_data_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_pkts(input string tag, input int n, input int budget);
    int c = 0;
    while (cnt_pkt < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, cnt_pkt, n);
    repeat (20) @(negedge clk);
  endtask

  // scoreboard: compare captured stream window against exp_q
  task automatic analyze(input string tag, input int from, input int exp_runs);
    int runs = 0;
    int nz   = 0;
    int bad  = 0;
    int gap  = 0;
    bit prev = 1'b0;
    bit started = 1'b0;
    got_q.delete();
    gap_q.delete();
    for (int i = from; i < mon_q.size(); i++) begin
      if (mon_q[i][8]) begin
        if (!prev) begin
          runs++;
          if (started) gap_q.push_back(gap);
        end
        got_q.push_back(mon_q[i][7:0]);
        started = 1'b1;
        gap = 0;
      end else begin
        if (mon_q[i][7:0] != 8'h00) nz++;
        gap++;
      end
      prev = mon_q[i][8];
    end
    tail_idle = gap;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] !== exp_q[k]) bad++;
    check({tag, " runs"}, runs, exp_runs);
    check({tag, " len"}, got_q.size(), exp_q.size());
    check({tag, " bytes"}, bad, 0);
    check({tag, " idle_zero"}, nz, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    pkt_data       = '0;
    pkt_data_valid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst ready", ready_out, 1'b0);
    check("rst valid", gmii_data_valid, 1'b0);
    check("rst data", gmii_data, 8'h00);
    check("rst cnt_pkt", cnt_pkt, 32'd0);
    check("rst cnt_drop", cnt_drop, 32'd0);
    rst_n = 1'b1;
    #1 check("rel ready", ready_out, 1'b0);
    @(negedge clk);
    check("rel ready after clk", ready_out, 1'b1);

    // 1: 64-byte packet with preamble, exact start latency
    exp_q.delete();
    base = mon_q.size();
    send_beat(2'b01, 4'h0, 8'h00);
    send_beat(2'b00, 4'h0, 8'h10);
    send_beat(2'b00, 4'h0, 8'h20);
    send_beat(2'b10, 4'hf, 8'h30);
    check("t1 lat0", gmii_data_valid, 1'b0);
    @(negedge clk);
    check("t1 lat1", gmii_data_valid, 1'b0);
    @(negedge clk);
    check("t1 lat2 valid", gmii_data_valid, 1'b1);
    check("t1 lat2 data", gmii_data, 8'h55);
    exp_frame_start();
    exp_bytes(8'h00, 64);
    wait_pkts("t1 cnt_pkt", 1, 200);
    analyze("t1", base, 1);
    check("t1 tail idle", tail_idle >= 12, 1'b1);

    // 2: tail valid=0 gives a 49-byte packet
    exp_q.delete();
    base = mon_q.size();
    send_beat(2'b01, 4'h3, 8'h40);
    send_beat(2'b00, 4'h0, 8'h50);
    send_beat(2'b00, 4'h0, 8'h60);
    send_beat(2'b10, 4'h0, 8'h70);
    exp_frame_start();
    exp_bytes(8'h40, 49);
    wait_pkts("t2 cnt_pkt", 2, 200);
    analyze("t2", base, 1);
    check("t2 last byte", got_q.size() > 0 ? got_q[got_q.size()-1] : 8'hxx, 8'h70);

    // 3: back-to-back frames, 32B then single 11 beat of 8B
    exp_q.delete();
    base = mon_q.size();
    send_beat(2'b01, 4'h0, 8'h80);
    send_beat(2'b10, 4'hf, 8'h90);
    send_beat(2'b11, 4'h7, 8'hA0);
    exp_frame_start();
    exp_bytes(8'h80, 32);
    exp_frame_start();
    exp_bytes(8'hA0, 8);
    wait_pkts("t3 cnt_pkt", 4, 300);
    analyze("t3", base, 2);
    check("t3 gap", gap_q.size() > 0 ? gap_q[0] : -1, 13);
    check("t3 cnt_drop", cnt_drop, 32'd0);

    // 4: fill the FIFO with one unterminated packet
    do_reset();
    exp_q.delete();
    base = mon_q.size();
    send_beat(2'b01, 4'h0, 8'h00);
    for (int i = 1; i < 254; i++) send_beat(2'b00, 4'h0, 8'(i));
    check("t4 ready at 254", ready_out, 1'b1);
    send_beat(2'b00, 4'h0, 8'hEE);
    check("t4 ready at 255", ready_out, 1'b0);
    send_beat(2'b00, 4'h0, 8'hEF);
    check("t4 drop after 256", cnt_drop, 32'd0);
    send_beat(2'b00, 4'h0, 8'hF0);
    check("t4 drop after 257", cnt_drop, 32'd1);
    repeat (10) @(negedge clk);
    check("t4 cnt_pkt", cnt_pkt, 32'd0);
    analyze("t4", base, 0);

    // 5: orphan body dropped; head,body,head,tail closes first packet at 32B
    do_reset();
    exp_q.delete();
    base = mon_q.size();
    send_beat(2'b00, 4'h0, 8'h11);
    repeat (10) @(negedge clk);
    check("t5 orphan drop", cnt_drop, 32'd1);
    check("t5 orphan no tx", cnt_pkt, 32'd0);
    send_beat(2'b01, 4'h0, 8'h20);
    send_beat(2'b00, 4'h0, 8'h30);
    send_beat(2'b01, 4'h0, 8'h40);
    send_beat(2'b10, 4'hf, 8'h50);
    exp_frame_start();
    exp_bytes(8'h20, 32);
    exp_frame_start();
    exp_bytes(8'h40, 32);
    wait_pkts("t5 cnt_pkt", 2, 300);
    analyze("t5", base, 2);
    check("t5 cnt_drop", cnt_drop, 32'd1);

    // 6: asynchronous reset in the middle of a data phase
    send_beat(2'b01, 4'h0, 8'h00);
    send_beat(2'b00, 4'h0, 8'h10);
    send_beat(2'b00, 4'h0, 8'h20);
    send_beat(2'b10, 4'hf, 8'h30);
    repeat (14) @(negedge clk);
    check("t6 mid valid", gmii_data_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst valid", gmii_data_valid, 1'b0);
    check("t6 rst data", gmii_data, 8'h00);
    check("t6 rst cnt_pkt", cnt_pkt, 32'd0);
    check("t6 rst cnt_drop", cnt_drop, 32'd0);
    check("t6 rst ready", ready_out, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    base = mon_q.size();
    send_beat(2'b01, 4'h0, 8'hC0);
    send_beat(2'b10, 4'hf, 8'hD0);
    exp_frame_start();
    exp_bytes(8'hC0, 32);
    wait_pkts("t6 cnt_pkt", 1, 200);
    analyze("t6", base, 1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
